// File: rtl/uart_baud_if.sv
// Control/status bundle between the baud-rate generator and the UART datapaths.
// The generator uses the slave modport; the modem/bench side uses master.
interface uart_baud_if #(
   parameter int unsigned DIV_WIDTH = 16,
   parameter int unsigned FRAC_BITS = 4
);
   logic                           enable;
   logic                           sync_clear;
   logic                           div_wr;
   logic [DIV_WIDTH+FRAC_BITS-1:0] div_in;
   logic [DIV_WIDTH+FRAC_BITS-1:0] div_cur;
   logic                           os_tick;
   logic                           baud_tick;
   logic                           baud_clk;

   modport master (
      output enable, sync_clear, div_wr, div_in,
      input  div_cur, os_tick, baud_tick, baud_clk
   );

   modport slave (
      input  enable, sync_clear, div_wr, div_in,
      output div_cur, os_tick, baud_tick, baud_clk
   );
endinterface

// File: rtl/uart_baud_gen.sv
// Fractional-N baud generator: prescaler plus fraction accumulator produces the
// oversample tick; an os index derives the bit tick and a square-wave baud clock.
module uart_baud_gen #(
   parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
   parameter int unsigned BAUD_DEFAULT = 9600,
   parameter int unsigned OVERSAMPLE   = 16,
   parameter int unsigned DIV_WIDTH    = 16,
   parameter int unsigned FRAC_BITS    = 4
) (
   input logic        clk,
   input logic        reset,
   uart_baud_if.slave bus
);
   localparam int unsigned DW   = DIV_WIDTH + FRAC_BITS;
   localparam int unsigned CW   = DIV_WIDTH + 1;
   localparam int unsigned OS_W = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0] OS_LAST      = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0] OS_HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [63:0] RST_NUM = 64'(CLK_FREQ_HZ) << FRAC_BITS;
   localparam logic [63:0] RST_DEN = 64'(BAUD_DEFAULT) * 64'(OVERSAMPLE);
   localparam logic [DW-1:0] DIV_RST = DW'((RST_NUM + (RST_DEN >> 1)) / RST_DEN);

   logic [DW-1:0]        div_act_q, div_act_d;
   logic [DW-1:0]        div_shd_q, div_shd_d;
   logic                 pend_q, pend_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [FRAC_BITS-1:0] acc_q, acc_d;
   logic                 ext_q, ext_d;
   logic [OS_W-1:0]      os_idx_q, os_idx_d;
   logic                 baud_clk_q, baud_clk_d;
   logic                 os_tick_q, os_tick_d;
   logic                 baud_tick_q, baud_tick_d;

   logic [DIV_WIDTH-1:0] div_int;
   logic [FRAC_BITS-1:0] div_frac;
   logic [FRAC_BITS:0]   frac_sum;
   logic                 wrap;

   // An integer part below 2 would allow a zero/one-cycle period; force it to 2.
   function automatic logic [DW-1:0] clamp_div(input logic [DW-1:0] d);
      logic [DW-1:0] r;
      r = d;
      if (d[DW-1:FRAC_BITS] < DIV_WIDTH'(2)) r[DW-1:FRAC_BITS] = DIV_WIDTH'(2);
      return r;
   endfunction

   assign div_int  = div_act_q[DW-1:FRAC_BITS];
   assign div_frac = div_act_q[FRAC_BITS-1:0];
   assign frac_sum = {1'b0, acc_q} + {1'b0, div_frac};
   // Compare cnt+1 against N in one extra bit so N = 2^DIV_WIDTH cannot overflow.
   assign wrap = bus.enable && !bus.sync_clear &&
                 (({1'b0, cnt_q} + CW'(1)) == ({1'b0, div_int} + CW'(ext_q)));

   always_comb begin
      div_act_d   = div_act_q;
      div_shd_d   = div_shd_q;
      pend_d      = pend_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      ext_d       = ext_q;
      os_idx_d    = os_idx_q;
      baud_clk_d  = baud_clk_q;
      os_tick_d   = 1'b0;
      baud_tick_d = 1'b0;

      if (bus.sync_clear) begin
         cnt_d      = '0;
         acc_d      = '0;
         ext_d      = 1'b0;
         os_idx_d   = '0;
         baud_clk_d = 1'b0;
         if (bus.div_wr) begin
            div_shd_d = bus.div_in;
            div_act_d = clamp_div(bus.div_in);
            pend_d    = 1'b0;
         end else if (pend_q) begin
            div_act_d = clamp_div(div_shd_q);
            pend_d    = 1'b0;
         end
      end else begin
         if (bus.enable) begin
            if (wrap) begin
               cnt_d          = '0;
               {ext_d, acc_d} = frac_sum;
               os_idx_d       = (os_idx_q == OS_LAST) ? '0 : os_idx_q + OS_W'(1);
               os_tick_d      = 1'b1;
               if (os_idx_q == OS_LAST) begin
                  baud_tick_d = 1'b1;
                  baud_clk_d  = 1'b1;
               end else if (os_idx_q == OS_HALF_LAST) begin
                  baud_clk_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + DIV_WIDTH'(1);
            end
         end
         // Swap only at a period boundary while running, immediately while idle.
         if (pend_q && (wrap || !bus.enable)) begin
            div_act_d = clamp_div(div_shd_q);
            pend_d    = 1'b0;
         end
         if (bus.div_wr) begin
            div_shd_d = bus.div_in;
            pend_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_act_q   <= DIV_RST;
         div_shd_q   <= DIV_RST;
         pend_q      <= 1'b0;
         cnt_q       <= '0;
         acc_q       <= '0;
         ext_q       <= 1'b0;
         os_idx_q    <= '0;
         baud_clk_q  <= 1'b0;
         os_tick_q   <= 1'b0;
         baud_tick_q <= 1'b0;
      end else begin
         div_act_q   <= div_act_d;
         div_shd_q   <= div_shd_d;
         pend_q      <= pend_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         ext_q       <= ext_d;
         os_idx_q    <= os_idx_d;
         baud_clk_q  <= baud_clk_d;
         os_tick_q   <= os_tick_d;
         baud_tick_q <= baud_tick_d;
      end
   end

   assign bus.div_cur   = div_act_q;
   assign bus.os_tick   = os_tick_q;
   assign bus.baud_tick = baud_tick_q;
   assign bus.baud_clk  = baud_clk_q;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: tick edge numbers are logged and compared against
// closed-form period arithmetic derived from the divisor value.
module tb_uart_baud_gen;
   localparam int unsigned DIV_WIDTH  = 16;
   localparam int unsigned FRAC_BITS  = 4;
   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned FRAC_ONE   = 16;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   int unsigned edge_cnt = 0;
   int unsigned os_q[$];
   int unsigned baud_q[$];
   int          n_cmp = 0;
   int          n_err = 0;

   uart_baud_if #(.DIV_WIDTH(DIV_WIDTH), .FRAC_BITS(FRAC_BITS)) bus ();

   uart_baud_gen #(
      .CLK_FREQ_HZ(100_000_000), .BAUD_DEFAULT(9600), .OVERSAMPLE(OVERSAMPLE),
      .DIV_WIDTH(DIV_WIDTH), .FRAC_BITS(FRAC_BITS)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   always @(negedge clk) begin
      if (bus.os_tick === 1'b1) os_q.push_back(edge_cnt);
      if (bus.baud_tick === 1'b1) baud_q.push_back(edge_cnt);
   end

   // Edge (relative to phase origin) that ends the k-th os period for divisor i + f/16.
   function automatic int unsigned t_end(input int unsigned i, input int unsigned f,
                                         input int unsigned k);
      return k * i + ((k - 1) * f) / FRAC_ONE;
   endfunction

   function automatic logic exp_bclk(input int unsigned i, input int unsigned f,
                                     input int unsigned rel);
      int unsigned m;
      m = 0;
      while (t_end(i, f, m + 1) <= rel) m++;
      return (m >= OVERSAMPLE) && ((m % OVERSAMPLE) < OVERSAMPLE / 2);
   endfunction

   function automatic int unsigned ref_rst_div();
      longint unsigned num, den;
      num = 64'd100_000_000 * 64'd16;
      den = 64'd9600 * 64'd16;
      return 32'((num + den / 2) / den);
   endfunction

   task automatic wait_edge(input int unsigned e);
      do @(negedge clk); while (edge_cnt < e);
   endtask

   task automatic start_phase(input logic wr, input logic [19:0] d, output int unsigned p);
      @(negedge clk);
      bus.enable = 1'b1; bus.sync_clear = 1'b1; bus.div_wr = wr; bus.div_in = d;
      @(posedge clk); #1;
      p = edge_cnt;
      os_q.delete(); baud_q.delete();
      @(negedge clk);
      bus.sync_clear = 1'b0; bus.div_wr = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1; bus.enable = 1'b1; bus.sync_clear = 1'b0; bus.div_wr = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.div_cur !== 20'(ref_rst_div())) begin
         n_err++; $display("FAIL reset_div_cur: got %0d want %0d", bus.div_cur, ref_rst_div());
      end
      n_cmp++;
      if (bus.os_tick !== 1'b0) begin n_err++; $display("FAIL reset_os_tick: got %b want 0", bus.os_tick); end
      n_cmp++;
      if (bus.baud_tick !== 1'b0) begin n_err++; $display("FAIL reset_baud_tick: got %b want 0", bus.baud_tick); end
      n_cmp++;
      if (bus.baud_clk !== 1'b0) begin n_err++; $display("FAIL reset_baud_clk: got %b want 0", bus.baud_clk); end
   endtask

   task automatic test_default_rate();
      int unsigned ie, f, p, w, bad;
      ie = ref_rst_div() / FRAC_ONE;
      f  = ref_rst_div() % FRAC_ONE;
      @(negedge clk);
      reset = 1'b0; bus.enable = 1'b1;
      p = edge_cnt;
      os_q.delete(); baud_q.delete();
      w = p + t_end(ie, f, 17) + 1;
      bad = 0;
      while (edge_cnt < w) begin
         @(negedge clk);
         if (bus.baud_clk !== exp_bclk(ie, f, edge_cnt - p)) bad++;
      end
      #1;
      n_cmp++;
      if (bad != 0) begin n_err++; $display("FAIL default_baud_clk bad cycles: got %0d want 0", bad); end
      n_cmp++;
      if (os_q.size() != 17) begin n_err++; $display("FAIL default_os_count: got %0d want 17", os_q.size()); end
      for (int k = 1; k <= 17 && k <= os_q.size(); k++) begin
         n_cmp++;
         if (os_q[k-1] !== p + t_end(ie, f, k)) begin
            n_err++; $display("FAIL default_os[%0d]: got edge %0d want %0d", k, os_q[k-1] - p, t_end(ie, f, k));
         end
      end
      n_cmp++;
      if (baud_q.size() != 1 || baud_q[0] !== p + t_end(ie, f, 16)) begin
         n_err++; $display("FAIL default_baud_tick: got n=%0d first=%0d want n=1 at %0d",
                           baud_q.size(), (baud_q.size() > 0) ? baud_q[0] - p : 0, t_end(ie, f, 16));
      end
   endtask

   task automatic test_divisor_rates();
      logic [19:0] tbl[$];
      tbl = '{20'h00040, 20'h00048, 20'h00013};
      repeat (5) tbl.push_back({16'($urandom_range(0, 9)), 4'($urandom_range(0, 15))});
      foreach (tbl[t]) begin
         int unsigned ie, f, p, w, bad;
         logic [19:0] want_cur;
         ie = (tbl[t][19:4] < 16'd2) ? 2 : 32'(tbl[t][19:4]);
         f  = 32'(tbl[t][3:0]);
         want_cur = {16'(ie), 4'(f)};
         @(negedge clk);
         bus.enable = 1'b0; bus.div_wr = 1'b1; bus.div_in = tbl[t];
         @(negedge clk);
         bus.div_wr = 1'b0;
         @(negedge clk);
         n_cmp++;
         if (bus.div_cur !== want_cur) begin
            n_err++; $display("FAIL rate%0d_div_cur: got %h want %h", t, bus.div_cur, want_cur);
         end
         start_phase(1'b0, 20'h0, p);
         w = p + t_end(ie, f, 33) + 1;
         bad = 0;
         while (edge_cnt < w) begin
            @(negedge clk);
            if (bus.baud_clk !== exp_bclk(ie, f, edge_cnt - p)) bad++;
         end
         #1;
         n_cmp++;
         if (bad != 0) begin n_err++; $display("FAIL rate%0d_baud_clk bad cycles: got %0d want 0", t, bad); end
         n_cmp++;
         if (os_q.size() != 33) begin n_err++; $display("FAIL rate%0d_os_count: got %0d want 33", t, os_q.size()); end
         for (int k = 1; k <= 33 && k <= os_q.size(); k++) begin
            n_cmp++;
            if (os_q[k-1] !== p + t_end(ie, f, k)) begin
               n_err++; $display("FAIL rate%0d_os[%0d]: got edge %0d want %0d", t, k, os_q[k-1] - p, t_end(ie, f, k));
            end
         end
         n_cmp++;
         if (baud_q.size() != 2 || baud_q[0] !== p + t_end(ie, f, 16) || baud_q[1] !== p + t_end(ie, f, 32)) begin
            n_err++; $display("FAIL rate%0d_baud_ticks: got n=%0d want 2 at %0d,%0d", t, baud_q.size(),
                              t_end(ie, f, 16), t_end(ie, f, 32));
         end
      end
   endtask

   task automatic test_mid_period_write();
      int unsigned p;
      int unsigned exp_os[$];
      start_phase(1'b1, 20'h00040, p);
      wait_edge(p + 5); bus.div_wr = 1'b1; bus.div_in = 20'h000A0;
      wait_edge(p + 6); bus.div_wr = 1'b0;
      wait_edge(p + 7);
      n_cmp++;
      if (bus.div_cur !== 20'h00040) begin n_err++; $display("FAIL midwr_before_wrap: got %h want 00040", bus.div_cur); end
      wait_edge(p + 8);
      n_cmp++;
      if (bus.div_cur !== 20'h000A0) begin n_err++; $display("FAIL midwr_after_wrap: got %h want 000a0", bus.div_cur); end
      wait_edge(p + 29); bus.div_wr = 1'b1; bus.div_in = 20'h00060;
      wait_edge(p + 30); bus.div_in = 20'h00080;
      wait_edge(p + 31); bus.div_wr = 1'b0;
      wait_edge(p + 37);
      n_cmp++;
      if (bus.div_cur !== 20'h000A0) begin n_err++; $display("FAIL dblwr_before_wrap: got %h want 000a0", bus.div_cur); end
      wait_edge(p + 38);
      n_cmp++;
      if (bus.div_cur !== 20'h00080) begin n_err++; $display("FAIL dblwr_last_wins: got %h want 00080", bus.div_cur); end
      wait_edge(p + 55); #1;
      exp_os = '{4, 8, 18, 28, 38, 46, 54};
      n_cmp++;
      if (os_q.size() != exp_os.size()) begin n_err++; $display("FAIL midwr_os_count: got %0d want %0d", os_q.size(), exp_os.size()); end
      foreach (exp_os[k]) if (k < os_q.size()) begin
         n_cmp++;
         if (os_q[k] !== p + exp_os[k]) begin
            n_err++; $display("FAIL midwr_os[%0d]: got edge %0d want %0d", k, os_q[k] - p, exp_os[k]);
         end
      end
   endtask

   task automatic test_sync_clear();
      int unsigned p, c1, c2, w;
      int unsigned exp_os[$];
      int unsigned exp_bd[$];
      start_phase(1'b1, 20'h00040, p);
      c1 = p + 40;
      wait_edge(c1 - 1); bus.sync_clear = 1'b1;
      wait_edge(c1); bus.sync_clear = 1'b0;
      n_cmp++;
      if (bus.os_tick !== 1'b0) begin n_err++; $display("FAIL clr1_no_tick: got %b want 0", bus.os_tick); end
      c2 = c1 + 84;
      wait_edge(c2 - 1);
      n_cmp++;
      if (bus.baud_clk !== 1'b1) begin n_err++; $display("FAIL clr2_baud_clk_before: got %b want 1", bus.baud_clk); end
      bus.sync_clear = 1'b1;
      wait_edge(c2); bus.sync_clear = 1'b0;
      n_cmp++;
      if (bus.baud_clk !== 1'b0 || bus.os_tick !== 1'b0) begin
         n_err++; $display("FAIL clr2_state: got baud_clk=%b os_tick=%b want 0 0", bus.baud_clk, bus.os_tick);
      end
      w = c2 + 65;
      wait_edge(w); #1;
      for (int k = 1; k <= 9; k++) exp_os.push_back(p + 4 * k);
      for (int k = 1; k <= 20; k++) exp_os.push_back(c1 + 4 * k);
      for (int k = 1; k <= 16; k++) exp_os.push_back(c2 + 4 * k);
      exp_bd = '{c1 + 64, c2 + 64};
      n_cmp++;
      if (os_q.size() != exp_os.size()) begin n_err++; $display("FAIL clr_os_count: got %0d want %0d", os_q.size(), exp_os.size()); end
      foreach (exp_os[k]) if (k < os_q.size()) begin
         n_cmp++;
         if (os_q[k] !== exp_os[k]) begin
            n_err++; $display("FAIL clr_os[%0d]: got edge %0d want %0d", k, os_q[k] - p, exp_os[k] - p);
         end
      end
      n_cmp++;
      if (baud_q.size() != 2 || baud_q[0] !== exp_bd[0] || baud_q[1] !== exp_bd[1]) begin
         n_err++; $display("FAIL clr_baud_ticks: got n=%0d want 2 at %0d,%0d", baud_q.size(), exp_bd[0] - p, exp_bd[1] - p);
      end
   endtask

   task automatic test_enable_gap();
      int unsigned p;
      int unsigned exp_os[$];
      start_phase(1'b1, 20'h00040, p);
      wait_edge(p + 5); bus.enable = 1'b0;
      wait_edge(p + 10); bus.enable = 1'b1;
      wait_edge(p + 74); #1;
      exp_os.push_back(p + 4);
      for (int k = 2; k <= 17; k++) exp_os.push_back(p + 4 * k + 5);
      n_cmp++;
      if (os_q.size() != exp_os.size()) begin n_err++; $display("FAIL gap_os_count: got %0d want %0d", os_q.size(), exp_os.size()); end
      foreach (exp_os[k]) if (k < os_q.size()) begin
         n_cmp++;
         if (os_q[k] !== exp_os[k]) begin
            n_err++; $display("FAIL gap_os[%0d]: got edge %0d want %0d", k, os_q[k] - p, exp_os[k] - p);
         end
      end
      n_cmp++;
      if (baud_q.size() != 1 || baud_q[0] !== p + 69) begin
         n_err++; $display("FAIL gap_baud_tick: got n=%0d first=%0d want n=1 at 69", baud_q.size(),
                           (baud_q.size() > 0) ? baud_q[0] - p : 0);
      end
   endtask

   initial begin
      bus.enable = 1'b0; bus.sync_clear = 1'b0; bus.div_wr = 1'b0; bus.div_in = '0;
      test_reset();
      test_default_rate();
      test_divisor_rates();
      test_mid_period_write();
      test_sync_clear();
      test_enable_gap();
      test_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Parametrised baud-rate generator for the UART transmitter and receiver datapaths. It derives an oversampling tick, a per-bit baud tick and a legacy square-wave baud_clk from the single system clock. The divisor is a fixed-point value with a fractional part, which gives accurate rates at any clock/baud ratio. The divisor is runtime-programmable and the phase can be restarted for receiver start-bit alignment.

## Interface
- CLK_FREQ_HZ, 100_000_000: system clock frequency; used only for the reset divisor.
- BAUD_DEFAULT, 9600: baud rate loaded at reset.
- OVERSAMPLE, 16: os_ticks per bit. Must be even and ≥4.
- DIV_WIDTH, 16: integer bits of divisor.
- FRAC_BITS, 4: fractional bits of divisor.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  counting enable; when low, counters hold and all tick outputs are 0.
- sync_clear  input  1  restart phase: prescaler, fraction accumulator and os index go to 0.
- div_wr  input  1  load div_in into the shadow divisor.
- div_in  input  DIV_WIDTH+FRAC_BITS  new divisor; upper DIV_WIDTH bits are the integer part, low FRAC_BITS bits are the fraction.
- div_cur  output  DIV_WIDTH+FRAC_BITS  divisor currently in use.
- os_tick  output  1  one-cycle pulse per oversample period.
- baud_tick  output  1  one-cycle pulse per bit period, coincident with an os_tick.
- baud_clk  output  1  square wave at the baud rate, approximately 50% duty.

## Operation
- Reset divisor DIV_RST = round(CLK_FREQ_HZ·2^FRAC_BITS / (BAUD_DEFAULT·OVERSAMPLE)). With defaults this is 10417 (int 651, frac 1).
- Registers:
  - div_act: active divisor.
  - div_shd: shadow divisor.
  - pend: load-pending flag.
  - cnt: DIV_WIDTH-bit prescaler.
  - acc: FRAC_BITS-bit fraction accumulator.
  - ext: 1-bit extend-next-period flag.
  - os_idx: log2(OVERSAMPLE) bits.
  - baud_clk.
- Period length N = int(div_act) + ext.
- When enable is high, each cycle:
  - If cnt == N−1: cnt←0, then {ext, acc} ← acc + frac(div_act) with carry into ext, then os_idx increments modulo OVERSAMPLE.
  - Otherwise cnt increments.
- Tick outputs:
  - os_tick is registered: it is 1 in the cycle after the edge on which cnt wrapped.
  - baud_tick = os_tick AND the wrap took os_idx from OVERSAMPLE−1 to 0.
- baud_clk:
  - Set to 1 on the edge producing baud_tick.
  - Cleared on the os_tick edge where os_idx goes from OVERSAMPLE/2−1 to OVERSAMPLE/2.
- Divisor load:
  - div_wr sets div_shd←div_in and pend←1.
  - If enable is low, div_act←div_shd on the next edge.
  - Otherwise div_act←div_shd on the next cnt wrap edge; the new N applies from the following period.
  - pend clears when div_act is loaded.
  - A second div_wr before the swap overwrites div_shd; last write wins.
- Integer part <2: clamped to 2 when loaded into div_act. The fraction is kept. div_cur shows the clamped value.
- sync_clear:
  - cnt, acc, ext, os_idx ← 0 and baud_clk ← 0.
  - The pending swap is applied immediately.
  - No tick on that edge.
  - sync_clear has priority over enable counting.
- Simultaneous div_wr and sync_clear: div_act←div_in directly.
- enable low:
  - All state holds except ticks, which are 0.
  - On re-enable, counting resumes mid-period.
- Reset: div_act = div_shd = DIV_RST; pend, cnt, acc, ext, os_idx, os_tick, baud_tick and baud_clk all ← 0. div_cur = DIV_RST.

## Timing
- With enable high from the first edge after reset deasserts, the first os_tick is high after edge int(div_act). Every later os_tick follows after N cycles, where N uses the ext computed at the previous wrap.
- Average os period = div_act / 2^FRAC_BITS cycles. Bit period = OVERSAMPLE os periods.
- The first baud_tick coincides with the OVERSAMPLE-th os_tick.
- Latency from div_wr to the new period: it takes effect on the period starting after the next wrap edge. Maximum delay is one old period plus one cycle.
- Counter arithmetic is unsigned. cnt never exceeds N−1 because the compare is ==, and the clamp guarantees N ≥ 2.

## Test plan
- Reset, enable=1, defaults → div_cur = 10417; first os_tick at cycle 651. Over 1 second of os_ticks the drift stays within ±1 cycle of 100e6/153600 per tick.
- div_wr div_in = {4, 0}, OVERSAMPLE=16 → os_tick every 4 cycles; baud_tick every 64 cycles; baud_clk high 32 cycles, low 32 cycles.
- div_in = {4, 8} → os periods follow the pattern 4,4,5,4,5,…; 16 os_ticks span exactly 72 cycles after the first period.
- div_in = {1, 3} → div_cur = {2, 3}; os period alternates 2/3 per accumulator carry, with no period shorter than 2.
- Mid-period div_wr {10, 0} while running at {4, 0} → the current 4-cycle period completes and the next period is 10. Double write {6,0} then {8,0} before the wrap → only {8,0} is applied.
- sync_clear pulsed at os_idx = 9 → no tick that cycle; next os_tick after int cycles with os_idx = 1; baud_tick 16 os_ticks after the clear. enable low for 5 cycles → ticks 0 and phase resumes shifted by 5 cycles.
